// File: rtl/ddr_aw_pkg.sv
// Shared definitions for the DDR AW burst scheduler.
//   sched_state_e  : scheduler FSM encoding (IDLE, ISSUE, DONE)
//   BURST_BYTES    : bytes covered by one AXI burst in the default build
//   BURST_SHIFT    : log2(BURST_BYTES), the number of forced-zero address LSBs
//   burst_shift()  : same shift for any BURST_LEN / BEAT_BYTES pair
package ddr_aw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_e;

    localparam int DEF_BURST_LEN  = 16;
    localparam int DEF_BEAT_BYTES = 16;
    localparam int BURST_BYTES    = DEF_BURST_LEN * DEF_BEAT_BYTES;
    localparam int BURST_SHIFT    = $clog2(BURST_BYTES);

    function automatic int burst_shift(input int burst_len, input int beat_bytes);
        return $clog2(burst_len * beat_bytes);
    endfunction

endpackage

// File: rtl/ddr_aw_rr_arb.sv
// Combinational round-robin pick.
//   valid      in  NUM_REQ  pending requests
//   ptr        in  3        index with highest priority this round
//   any        out 1        at least one request is valid
//   gnt_onehot out NUM_REQ  one-hot winner (0 when nothing is valid)
//   gnt_idx    out 3        index of the winner (0 when nothing is valid)
// The winner is the first valid index at or after ptr, wrapping modulo NUM_REQ.
module ddr_aw_rr_arb
    import ddr_aw_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [2:0]         ptr,
    output logic               any,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [2:0]         gnt_idx
);

    // Pad the request vector to eight entries so a 3-bit index is always in range.
    logic [7:0] valid_ext;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ext
            if (gi < NUM_REQ) begin : g_used
                assign valid_ext[gi] = valid[gi];
            end else begin : g_pad
                assign valid_ext[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        logic [2:0] cand;
        any        = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = 3'((int'(ptr) + k) % NUM_REQ);
            if (!any && valid_ext[cand]) begin
                any        = 1'b1;
                gnt_idx    = cand;
                gnt_onehot = NUM_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/ddr_aw_burst_sched.sv
// Round-robin AW burst scheduler in front of the DDR write-address FIFO.
// Each requester posts a start address and a burst count; the request is split
// into BURST_LEN x BEAT_BYTES bursts and one aligned burst address is pushed per
// FIFO word. req_done pulses once the last burst of the request is queued.
//   clk, rst_n         clock and asynchronous active-low reset
//   req_valid/addr/cnt per-requester request (flattened, slice i at i*WIDTH)
//   req_ready          one-cycle accept pulse, one-hot
//   req_done           one-cycle pulse after the last push of the request
//   busy               scheduler not idle
//   grant_id           current or most recent granted requester
//   fifo_wr_en/data    FIFO push interface
//   fifo_wr_full       FIFO full
//   fifo_almost_full   FIFO has at most one free entry
// Optional build macro DDR_AW_PERF_CNT_EN adds saturating counters:
//   stall_cnt          ISSUE cycles without a push
//   burst_cnt          total pushes
// All outputs come straight from registers.
module ddr_aw_burst_sched
    import ddr_aw_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int BEAT_BYTES = DEF_BEAT_BYTES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*CNT_WIDTH-1:0]  req_cnt,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          busy,
    output logic [2:0]                    grant_id,
    output logic                          fifo_wr_en,
    output logic [ADDR_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_wr_full,
    input  logic                          fifo_almost_full
`ifdef DDR_AW_PERF_CNT_EN
    ,
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   burst_cnt
`endif
);

    localparam int SHIFT = burst_shift(BURST_LEN, BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] BURST_INC  = ADDR_WIDTH'(1) << SHIFT;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(BURST_INC - ADDR_WIDTH'(1));

    sched_state_e state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
    logic [CNT_WIDTH-1:0]  remain_reg, remain_next;
    logic [2:0]            grant_id_reg, grant_id_next;
    logic [2:0]            rr_ptr_reg, rr_ptr_next;
    logic [NUM_REQ-1:0]    req_ready_reg, req_ready_next;
    logic [NUM_REQ-1:0]    req_done_reg, req_done_next;
    logic                  busy_reg, busy_next;
    logic                  wr_en_reg, wr_en_next;
    logic [ADDR_WIDTH-1:0] wr_data_reg, wr_data_next;

    logic                  arb_any;
    logic [NUM_REQ-1:0]    arb_onehot;
    logic [2:0]            arb_idx;
    logic                  push;

    // Request fields as eight-entry arrays so the 3-bit grant index selects directly.
    logic [ADDR_WIDTH-1:0] addr_arr [8];
    logic [CNT_WIDTH-1:0]  cnt_arr  [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < NUM_REQ) begin : g_used
                assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
                assign cnt_arr[gi]  = req_cnt[gi*CNT_WIDTH +: CNT_WIDTH];
            end else begin : g_pad
                assign addr_arr[gi] = '0;
                assign cnt_arr[gi]  = '0;
            end
        end
    endgenerate

    ddr_aw_rr_arb #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .valid      (req_valid),
        .ptr        (rr_ptr_reg),
        .any        (arb_any),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx)
    );

    // almost_full leaves one slot for the push already registered, so the
    // FIFO cannot be written while full.
    assign push = (state_reg == ST_ISSUE) && !fifo_wr_full && !fifo_almost_full;

    always_comb begin
        state_next     = state_reg;
        cur_addr_next  = cur_addr_reg;
        remain_next    = remain_reg;
        grant_id_next  = grant_id_reg;
        rr_ptr_next    = rr_ptr_reg;
        req_ready_next = '0;
        req_done_next  = '0;
        wr_en_next     = 1'b0;
        wr_data_next   = wr_data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (arb_any) begin
                    req_ready_next = arb_onehot;
                    grant_id_next  = arb_idx;
                    cur_addr_next  = addr_arr[arb_idx] & ALIGN_MASK;
                    remain_next    = cnt_arr[arb_idx];
                    state_next     = (cnt_arr[arb_idx] == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (push) begin
                    wr_en_next    = 1'b1;
                    wr_data_next  = cur_addr_reg;
                    cur_addr_next = cur_addr_reg + BURST_INC;
                    remain_next   = remain_reg - CNT_WIDTH'(1);
                    if (remain_reg == CNT_WIDTH'(1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                req_done_next = NUM_REQ'(1) << grant_id_reg;
                rr_ptr_next   = (grant_id_reg == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_reg + 3'd1;
                state_next    = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cur_addr_reg  <= '0;
            remain_reg    <= '0;
            grant_id_reg  <= '0;
            rr_ptr_reg    <= '0;
            req_ready_reg <= '0;
            req_done_reg  <= '0;
            busy_reg      <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            cur_addr_reg  <= cur_addr_next;
            remain_reg    <= remain_next;
            grant_id_reg  <= grant_id_next;
            rr_ptr_reg    <= rr_ptr_next;
            req_ready_reg <= req_ready_next;
            req_done_reg  <= req_done_next;
            busy_reg      <= busy_next;
            wr_en_reg     <= wr_en_next;
            wr_data_reg   <= wr_data_next;
        end
    end

    assign req_ready    = req_ready_reg;
    assign req_done     = req_done_reg;
    assign busy         = busy_reg;
    assign grant_id     = grant_id_reg;
    assign fifo_wr_en   = wr_en_reg;
    assign fifo_wr_data = wr_data_reg;

`ifdef DDR_AW_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] burst_cnt_reg;
    logic        issue_stall;

    assign issue_stall = (state_reg == ST_ISSUE) && !push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            burst_cnt_reg <= '0;
        end else begin
            if (issue_stall && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (push && (burst_cnt_reg != '1)) begin
                burst_cnt_reg <= burst_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign burst_cnt = burst_cnt_reg;
`endif

endmodule
